riscv_v_csr_arb: RTL and testbench
==================================

# riscv_v_csr_arb

Two-requester write arbiter that sits in front of the vector CSR control pipeline. It accepts CSR write requests from the scalar core (ext) and from the vector decode unit (vec) over valid/ready handshakes, each into a one-entry buffer. It issues at most one write per CSR per cycle as ID-stage one-hot write strobes, and delays the write data to the EXE stage. The CSR control stage's "no simultaneous ext/vec write to the same CSR" invariant therefore holds by construction.

## Interface
- CNT_WIDTH, 16, width of the saturating conflict counter
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset (asserted when 0)
- stall  in  1  pipeline stall; freezes grants, buffers, rr pointer and data delay line
- flush  in  1  pipeline flush; empties both buffers, no grants this cycle
- ext_req_valid / ext_req_ready  in / out  1  scalar-core request handshake
- ext_req_sel  in  RISCV_V_CSR_SEL_WIDTH  target CSR (riscv_v_csr_sel_t)
- ext_req_data  in  riscv_data_t  write data
- vec_req_valid / vec_req_ready  in / out  1  vector-unit request handshake
- vec_req_sel  in  RISCV_V_CSR_SEL_WIDTH  target CSR
- vec_req_data  in  riscv_v_data_t  write data
- ext_wr_{vsstatus,vtype,vl,vstart,vxrm,vxsat}_id  out  1 each  one-hot ext write strobes
- vec_wr_{vsstatus,vtype,vl,vstart,vxrm,vxsat}_id  out  1 each  one-hot vec write strobes
- ext_data_out_exe  out  riscv_data_t  granted ext data, EXE-aligned
- vec_data_out_exe  out  riscv_v_data_t  granted vec data, EXE-aligned
- err_invalid_sel  out  1  registered pulse: a buffered request had an invalid sel
- conflict_cnt  out  CNT_WIDTH  saturating count of same-CSR conflicts

## Operation
- Buffers:
  - Each side has one entry {valid, sel, data}.
  - Accept on valid && ready.
  - ready_x = ~stall & ~flush & (~buf_valid_x | issue_x).
- Issue condition: buffer valid, ~stall, ~flush, grant.
- Grant rules, decided each cycle from buffer contents:
  - Only one buffer valid: that buffer is granted.
  - Both valid, sel differs: both are granted in the same cycle.
  - Both valid, sel equal (conflict): rr_ptr decides (0 = ext wins, 1 = vec wins). After the grant, rr_ptr := loser side. The loser stays buffered and ready deasserts for it.
- Strobes: the issued side drives the one-hot strobe decoded from sel; all other strobes are 0. Encoding: 0 vsstatus, 1 vtype, 2 vl, 3 vstart, 4 vxrm, 5 vxsat.
- Invalid sel (6, 7):
  - The entry is consumed at issue with no strobe.
  - err_invalid_sel pulses for one cycle, the cycle after.
  - An invalid sel never wins against a valid sel: no conflict is recorded and both sides issue.
- conflict_cnt: +1 in every conflict cycle that issues; holds at all-ones.
- Data path: issued data enters a RISCV_V_ID_2_EXE_LATENCY-deep delay line, enabled by ~stall.
  - Non-issuing cycles shift in '0.
  - Latency 0 is a combinational passthrough.
- Flush: both buffers invalidated; the delay line is not flushed (the CSR control stage drops the enables).
- Reset (rst=0):
  - Buffers empty, rr_ptr=0, conflict_cnt=0, err_invalid_sel=0.
  - Delay line contents 0; all strobes 0; ready outputs 0 during reset.

## Timing
- Request accepted at cycle N: strobe no earlier than N+1; data on *_data_out_exe at N+1+RISCV_V_ID_2_EXE_LATENCY.
- Back-to-back throughput: 1 write per side per cycle when there is no conflict.
- Worst-case wait under continuous conflict: 1 extra cycle (round-robin alternation).
- Stall in the issue cycle: strobes 0, buffer retained, issue deferred to the first non-stall cycle.
- Reset mid-operation: buffered requests are lost; requesters must re-present after reset.
- Outputs: strobes are combinational from registered state and stall/flush; err_invalid_sel and conflict_cnt are registered.

## Structure
- riscv_v_pkg additions:
  - riscv_v_csr_sel_t enum
  - RISCV_V_CSR_SEL_WIDTH = 3
  - RISCV_V_CSR_SEL_NUM = 6
- Sub-module: riscv_v_stage for both data delay lines (rst_val '0, flush tied 0, en = ~stall).
- Sel-to-one-hot decode is a function in riscv_v_pkg, shared with riscv_v_csr_ctrl users.

## Test plan
- Single ext request, sel=2 (vl), data 0x10: ext_wr_vl_id=1 at N+1, ext_data_out_exe=0x10 at N+1+L, ext_req_ready high throughout.
- ext sel=1 (vtype) and vec sel=4 (vxrm) in the same cycle: both strobes at N+1 with no conflict, conflict_cnt stays 0.
- ext and vec both sel=3 (vstart), held valid for 4 requests each:
  - Grants alternate ext, vec, ext, vec.
  - conflict_cnt=1 after the first cycle; no cycle has both vstart strobes.
- vec request sel=6: vec_req_ready stays high, no strobe, err_invalid_sel=1 for exactly one cycle at N+2.
- Both buffers full, stall=1 for 3 cycles then flush=1:
  - No strobes, readys 0.
  - Buffers empty after the flush; the next request issues normally.
- conflict_cnt preloaded by 2^16 conflicts: stays at 0xFFFF; rst=0 mid-burst gives all outputs 0 and rr_ptr=0 on the next cycle.

Source files
------------

// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types and constants, plus the CSR select decode helpers
// used by the write arbiter and the CSR control stage.
package riscv_v_pkg;

    localparam int RISCV_XLEN               = 32;
    localparam int RISCV_V_ELEN             = 32;
    localparam int RISCV_V_ID_2_EXE_LATENCY = 1;
    localparam int RISCV_V_CSR_SEL_WIDTH    = 3;
    localparam int RISCV_V_CSR_SEL_NUM      = 6;

    typedef logic [RISCV_XLEN-1:0]   riscv_data_t;
    typedef logic [RISCV_V_ELEN-1:0] riscv_v_data_t;

    typedef enum logic [RISCV_V_CSR_SEL_WIDTH-1:0] {
        CSR_VSSTATUS = 3'd0,
        CSR_VTYPE    = 3'd1,
        CSR_VL       = 3'd2,
        CSR_VSTART   = 3'd3,
        CSR_VXRM     = 3'd4,
        CSR_VXSAT    = 3'd5
    } riscv_v_csr_sel_t;

    function automatic logic riscv_v_csr_sel_valid(
        input logic [RISCV_V_CSR_SEL_WIDTH-1:0] sel
    );
        return sel < RISCV_V_CSR_SEL_WIDTH'(RISCV_V_CSR_SEL_NUM);
    endfunction

    // Out-of-range selects decode to all zeros.
    function automatic logic [RISCV_V_CSR_SEL_NUM-1:0] riscv_v_csr_onehot(
        input logic [RISCV_V_CSR_SEL_WIDTH-1:0] sel
    );
        logic [RISCV_V_CSR_SEL_NUM-1:0] oh;
        oh = '0;
        for (int i = 0; i < RISCV_V_CSR_SEL_NUM; i++) begin
            if (sel == i[RISCV_V_CSR_SEL_WIDTH-1:0]) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/riscv_v_stage.sv
// Enable-gated pipeline delay line of LATENCY registers; LATENCY 0 is a wire.
module riscv_v_stage #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] rst_val_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (LATENCY == 0) begin : g_pass
            assign q_o = d_i;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [LATENCY];

            always_ff @(posedge clk) begin
                if (!rst_ni || flush_i) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        stage_q[i] <= rst_val_i;
                    end
                end else if (en_i) begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < LATENCY; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/riscv_v_csr_arb.sv
// Arbitrates ext/vec vector-CSR writes so that no CSR sees two writes in one
// cycle; issues ID-stage one-hot strobes and EXE-aligned write data.
module riscv_v_csr_arb
    import riscv_v_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             stall,
    input  logic                             flush,
    input  logic                             ext_req_valid,
    output logic                             ext_req_ready,
    input  logic [RISCV_V_CSR_SEL_WIDTH-1:0] ext_req_sel,
    input  riscv_data_t                      ext_req_data,
    input  logic                             vec_req_valid,
    output logic                             vec_req_ready,
    input  logic [RISCV_V_CSR_SEL_WIDTH-1:0] vec_req_sel,
    input  riscv_v_data_t                    vec_req_data,
    output logic                             ext_wr_vsstatus_id,
    output logic                             ext_wr_vtype_id,
    output logic                             ext_wr_vl_id,
    output logic                             ext_wr_vstart_id,
    output logic                             ext_wr_vxrm_id,
    output logic                             ext_wr_vxsat_id,
    output logic                             vec_wr_vsstatus_id,
    output logic                             vec_wr_vtype_id,
    output logic                             vec_wr_vl_id,
    output logic                             vec_wr_vstart_id,
    output logic                             vec_wr_vxrm_id,
    output logic                             vec_wr_vxsat_id,
    output riscv_data_t                      ext_data_out_exe,
    output riscv_v_data_t                    vec_data_out_exe,
    output logic                             err_invalid_sel,
    output logic [CNT_WIDTH-1:0]             conflict_cnt
);

    logic                             ext_valid_q, ext_valid_d;
    logic [RISCV_V_CSR_SEL_WIDTH-1:0] ext_sel_q, ext_sel_d;
    riscv_data_t                      ext_data_q, ext_data_d;
    logic                             vec_valid_q, vec_valid_d;
    logic [RISCV_V_CSR_SEL_WIDTH-1:0] vec_sel_q, vec_sel_d;
    riscv_v_data_t                    vec_data_q, vec_data_d;
    logic                             rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0]             cnt_q, cnt_d;
    logic                             err_q, err_d;

    logic issue_ok, ext_sel_ok, vec_sel_ok, conflict;
    logic ext_issue, vec_issue;
    logic [RISCV_V_CSR_SEL_NUM-1:0] ext_stb, vec_stb;
    riscv_data_t                    ext_stage_in;
    riscv_v_data_t                  vec_stage_in;

    // Reset, stall and flush all block issue and acceptance.
    assign issue_ok   = rst & ~stall & ~flush;
    assign ext_sel_ok = riscv_v_csr_sel_valid(ext_sel_q);
    assign vec_sel_ok = riscv_v_csr_sel_valid(vec_sel_q);
    assign conflict   = ext_valid_q & vec_valid_q & ext_sel_ok & vec_sel_ok
                      & (ext_sel_q == vec_sel_q);

    assign ext_issue = issue_ok & ext_valid_q & (~conflict | ~rr_ptr_q);
    assign vec_issue = issue_ok & vec_valid_q & (~conflict | rr_ptr_q);

    assign ext_req_ready = issue_ok & (~ext_valid_q | ext_issue);
    assign vec_req_ready = issue_ok & (~vec_valid_q | vec_issue);

    always_comb begin
        ext_valid_d = ext_valid_q;
        ext_sel_d   = ext_sel_q;
        ext_data_d  = ext_data_q;
        if (flush) begin
            ext_valid_d = 1'b0;
        end else if (ext_req_valid && ext_req_ready) begin
            ext_valid_d = 1'b1;
            ext_sel_d   = ext_req_sel;
            ext_data_d  = ext_req_data;
        end else if (ext_issue) begin
            ext_valid_d = 1'b0;
        end
    end

    always_comb begin
        vec_valid_d = vec_valid_q;
        vec_sel_d   = vec_sel_q;
        vec_data_d  = vec_data_q;
        if (flush) begin
            vec_valid_d = 1'b0;
        end else if (vec_req_valid && vec_req_ready) begin
            vec_valid_d = 1'b1;
            vec_sel_d   = vec_req_sel;
            vec_data_d  = vec_req_data;
        end else if (vec_issue) begin
            vec_valid_d = 1'b0;
        end
    end

    // Winner of an issuing conflict hands priority to the loser.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        if (conflict && issue_ok) begin
            rr_ptr_d = ~rr_ptr_q;
            if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        err_d = (ext_issue & ~ext_sel_ok) | (vec_issue & ~vec_sel_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ext_valid_q <= 1'b0;
            ext_sel_q   <= '0;
            ext_data_q  <= '0;
            vec_valid_q <= 1'b0;
            vec_sel_q   <= '0;
            vec_data_q  <= '0;
            rr_ptr_q    <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            ext_valid_q <= ext_valid_d;
            ext_sel_q   <= ext_sel_d;
            ext_data_q  <= ext_data_d;
            vec_valid_q <= vec_valid_d;
            vec_sel_q   <= vec_sel_d;
            vec_data_q  <= vec_data_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign ext_stb = ext_issue ? riscv_v_csr_onehot(ext_sel_q) : '0;
    assign vec_stb = vec_issue ? riscv_v_csr_onehot(vec_sel_q) : '0;

    assign ext_wr_vsstatus_id = ext_stb[0];
    assign ext_wr_vtype_id    = ext_stb[1];
    assign ext_wr_vl_id       = ext_stb[2];
    assign ext_wr_vstart_id   = ext_stb[3];
    assign ext_wr_vxrm_id     = ext_stb[4];
    assign ext_wr_vxsat_id    = ext_stb[5];
    assign vec_wr_vsstatus_id = vec_stb[0];
    assign vec_wr_vtype_id    = vec_stb[1];
    assign vec_wr_vl_id       = vec_stb[2];
    assign vec_wr_vstart_id   = vec_stb[3];
    assign vec_wr_vxrm_id     = vec_stb[4];
    assign vec_wr_vxsat_id    = vec_stb[5];

    assign ext_stage_in = ext_issue ? ext_data_q : '0;
    assign vec_stage_in = vec_issue ? vec_data_q : '0;

    riscv_v_stage #(
        .WIDTH   (RISCV_XLEN),
        .LATENCY (RISCV_V_ID_2_EXE_LATENCY)
    ) u_ext_stage (
        .clk       (clk),
        .rst_ni    (rst),
        .en_i      (~stall),
        .flush_i   (1'b0),
        .rst_val_i ('0),
        .d_i       (ext_stage_in),
        .q_o       (ext_data_out_exe)
    );

    riscv_v_stage #(
        .WIDTH   (RISCV_V_ELEN),
        .LATENCY (RISCV_V_ID_2_EXE_LATENCY)
    ) u_vec_stage (
        .clk       (clk),
        .rst_ni    (rst),
        .en_i      (~stall),
        .flush_i   (1'b0),
        .rst_val_i ('0),
        .d_i       (vec_stage_in),
        .q_o       (vec_data_out_exe)
    );

    assign err_invalid_sel = err_q;
    assign conflict_cnt    = cnt_q;

endmodule

// File: tb/tb_riscv_v_csr_arb.sv
// Scoreboard bench for riscv_v_csr_arb: accepted requests push expected
// strobes/data, a negedge monitor pops and compares them as the DUT issues.
module tb_riscv_v_csr_arb;
    import riscv_v_pkg::*;

    localparam int L = RISCV_V_ID_2_EXE_LATENCY;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        ext_req_valid, ext_req_ready, vec_req_valid, vec_req_ready;
    logic [2:0]  ext_req_sel, vec_req_sel;
    logic [31:0] ext_req_data, vec_req_data;
    logic        ext_wr_vsstatus_id, ext_wr_vtype_id, ext_wr_vl_id;
    logic        ext_wr_vstart_id, ext_wr_vxrm_id, ext_wr_vxsat_id;
    logic        vec_wr_vsstatus_id, vec_wr_vtype_id, vec_wr_vl_id;
    logic        vec_wr_vstart_id, vec_wr_vxrm_id, vec_wr_vxsat_id;
    logic [31:0] ext_data_out_exe, vec_data_out_exe;
    logic        err_invalid_sel;
    logic [15:0] conflict_cnt;

    always #5 clk = ~clk;

    riscv_v_csr_arb #(.CNT_WIDTH(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .stall              (stall),
        .flush              (flush),
        .ext_req_valid      (ext_req_valid),
        .ext_req_ready      (ext_req_ready),
        .ext_req_sel        (ext_req_sel),
        .ext_req_data       (ext_req_data),
        .vec_req_valid      (vec_req_valid),
        .vec_req_ready      (vec_req_ready),
        .vec_req_sel        (vec_req_sel),
        .vec_req_data       (vec_req_data),
        .ext_wr_vsstatus_id (ext_wr_vsstatus_id),
        .ext_wr_vtype_id    (ext_wr_vtype_id),
        .ext_wr_vl_id       (ext_wr_vl_id),
        .ext_wr_vstart_id   (ext_wr_vstart_id),
        .ext_wr_vxrm_id     (ext_wr_vxrm_id),
        .ext_wr_vxsat_id    (ext_wr_vxsat_id),
        .vec_wr_vsstatus_id (vec_wr_vsstatus_id),
        .vec_wr_vtype_id    (vec_wr_vtype_id),
        .vec_wr_vl_id       (vec_wr_vl_id),
        .vec_wr_vstart_id   (vec_wr_vstart_id),
        .vec_wr_vxrm_id     (vec_wr_vxrm_id),
        .vec_wr_vxsat_id    (vec_wr_vxsat_id),
        .ext_data_out_exe   (ext_data_out_exe),
        .vec_data_out_exe   (vec_data_out_exe),
        .err_invalid_sel    (err_invalid_sel),
        .conflict_cnt       (conflict_cnt)
    );

    typedef struct { logic [5:0] stb; logic [31:0] data; } exp_t;
    typedef struct { int due; logic [31:0] data; } pend_t;

    exp_t  exp_ext[$], exp_vec[$];
    pend_t pend_ext[$], pend_vec[$];
    bit    glog[$];
    bit    sb_en = 1'b1;
    bit    log_en = 1'b0;
    int    cyc = 0;
    int    last_ext_cyc = -1, last_vec_cyc = -1;
    int    n_tests = 0, n_fail = 0;

    wire [5:0] ext_stb = {ext_wr_vxsat_id, ext_wr_vxrm_id, ext_wr_vstart_id,
                          ext_wr_vl_id, ext_wr_vtype_id, ext_wr_vsstatus_id};
    wire [5:0] vec_stb = {vec_wr_vxsat_id, vec_wr_vxrm_id, vec_wr_vstart_id,
                          vec_wr_vl_id, vec_wr_vtype_id, vec_wr_vsstatus_id};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        pend_t p;
        if (sb_en) begin
            if (ext_stb != 6'd0) begin
                $display("[TB] cyc %0d ext write stb=%b", cyc, ext_stb);
                last_ext_cyc = cyc;
                if (log_en) glog.push_back(1'b0);
                if (exp_ext.size() == 0) check_eq("ext_unexpected_stb", ext_stb, 0);
                else begin
                    e = exp_ext.pop_front();
                    check_eq("ext_stb", ext_stb, e.stb);
                    pend_ext.push_back('{cyc + L, e.data});
                end
            end
            if (vec_stb != 6'd0) begin
                $display("[TB] cyc %0d vec write stb=%b", cyc, vec_stb);
                last_vec_cyc = cyc;
                if (log_en) glog.push_back(1'b1);
                if (exp_vec.size() == 0) check_eq("vec_unexpected_stb", vec_stb, 0);
                else begin
                    e = exp_vec.pop_front();
                    check_eq("vec_stb", vec_stb, e.stb);
                    pend_vec.push_back('{cyc + L, e.data});
                end
            end
            if ((ext_stb & vec_stb) != 6'd0) check_eq("same_csr_both", ext_stb & vec_stb, 0);
            if (pend_ext.size() != 0 && pend_ext[0].due == cyc) begin
                p = pend_ext.pop_front();
                check_eq("ext_data_exe", ext_data_out_exe, p.data);
            end
            if (pend_vec.size() != 0 && pend_vec[0].due == cyc) begin
                p = pend_vec.pop_front();
                check_eq("vec_data_exe", vec_data_out_exe, p.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit side, input logic [2:0] sel, input logic [31:0] data, input bit push);
        bit acc;
        int t;
        exp_t e;
        acc = 1'b0;
        t = 0;
        if (side) begin vec_req_valid = 1'b1; vec_req_sel = sel; vec_req_data = data; end
        else      begin ext_req_valid = 1'b1; ext_req_sel = sel; ext_req_data = data; end
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = side ? vec_req_ready : ext_req_ready;
            step();
            t++;
        end
        if (side) vec_req_valid = 1'b0; else ext_req_valid = 1'b0;
        check_eq(side ? "vec_accept" : "ext_accept", acc, 1);
        $display("[TB] cyc %0d %s request sel=%0d data=0x%0h accepted=%0d",
                 cyc, side ? "vec" : "ext", sel, data, acc);
        if (acc && push && sel < 3'd6) begin
            e.stb  = 6'b000001 << sel;
            e.data = data;
            if (side) exp_vec.push_back(e); else exp_ext.push_back(e);
        end
    endtask

    task automatic drain();
        repeat (L + 4) step();
        check_eq("ext_exp_left", exp_ext.size(), 0);
        check_eq("vec_exp_left", vec_exp_left_size(), 0);
        check_eq("ext_data_left", pend_ext.size(), 0);
        check_eq("vec_data_left", pend_vec.size(), 0);
    endtask

    function automatic int vec_exp_left_size();
        return exp_vec.size();
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ext_ready"}, ext_req_ready, 0);
        check_eq({tag, "_vec_ready"}, vec_req_ready, 0);
        check_eq({tag, "_ext_stb"}, ext_stb, 0);
        check_eq({tag, "_vec_stb"}, vec_stb, 0);
    endtask

    initial begin : watchdog
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int c0;
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        ext_req_valid = 1'b0; ext_req_sel = 3'd0; ext_req_data = '0;
        vec_req_valid = 1'b0; vec_req_sel = 3'd0; vec_req_data = '0;

        // Reset state
        repeat (2) step();
        @(negedge clk);
        check_idle_outputs("rst");
        check_eq("rst_cnt", conflict_cnt, 0);
        check_eq("rst_err", err_invalid_sel, 0);
        check_eq("rst_ext_data", ext_data_out_exe, 0);
        check_eq("rst_vec_data", vec_data_out_exe, 0);
        step();
        rst = 1'b1;

        // Single ext write to vl
        @(negedge clk);
        check_eq("t1_ready_before", ext_req_ready, 1);
        step();
        send(1'b0, 3'd2, 32'h10, 1'b1);
        @(negedge clk);
        check_eq("t1_ready_issue", ext_req_ready, 1);
        drain();

        // Different CSRs in the same cycle
        fork
            send(1'b0, 3'd1, 32'h11, 1'b1);
            send(1'b1, 3'd4, 32'h22, 1'b1);
        join
        drain();
        check_eq("t2_same_cycle", last_ext_cyc, last_vec_cyc);
        check_eq("t2_cnt", conflict_cnt, 0);

        // Continuous conflict on vstart
        glog.delete();
        log_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) send(1'b0, 3'd3, 32'h30 + i, 1'b1);
            end
            begin
                for (int i = 0; i < 4; i++) send(1'b1, 3'd3, 32'h40 + i, 1'b1);
            end
            begin
                int t;
                t = 0;
                @(negedge clk);
                while (!ext_wr_vstart_id && t < 20) begin
                    @(negedge clk);
                    t++;
                end
                check_eq("t3_first_ext", ext_wr_vstart_id, 1);
                step();
                check_eq("t3_cnt_first", conflict_cnt, 1);
            end
        join
        drain();
        log_en = 1'b0;
        check_eq("t3_grants", glog.size(), 8);
        for (int i = 0; i < 8 && i < glog.size(); i++)
            check_eq("t3_order", glog[i], i % 2);
        check_eq("t3_cnt_total", conflict_cnt, 7);

        // Invalid select on vec
        c0 = 32'(conflict_cnt);
        send(1'b1, 3'd6, 32'h66, 1'b0);
        @(negedge clk);
        check_eq("t4_vec_ready", vec_req_ready, 1);
        check_eq("t4_err_n1", err_invalid_sel, 0);
        step();
        @(negedge clk);
        check_eq("t4_err_n2", err_invalid_sel, 1);
        step();
        @(negedge clk);
        check_eq("t4_err_n3", err_invalid_sel, 0);
        step();
        fork
            send(1'b0, 3'd3, 32'h77, 1'b1);
            send(1'b1, 3'd7, 32'h78, 1'b1);
        join
        drain();
        check_eq("t4_no_conflict", conflict_cnt, c0);

        // Stall with both buffers full, then flush
        ext_req_valid = 1'b1; ext_req_sel = 3'd0; ext_req_data = 32'hE0;
        vec_req_valid = 1'b1; vec_req_sel = 3'd5; vec_req_data = 32'hE5;
        @(negedge clk);
        check_eq("t5_ext_ready", ext_req_ready, 1);
        check_eq("t5_vec_ready", vec_req_ready, 1);
        step();
        ext_req_valid = 1'b0; vec_req_valid = 1'b0; stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle_outputs("t5_stall");
            step();
        end
        stall = 1'b0; flush = 1'b1;
        @(negedge clk);
        check_idle_outputs("t5_flush");
        step();
        flush = 1'b0;
        @(negedge clk);
        check_eq("t5_post_ext_ready", ext_req_ready, 1);
        check_eq("t5_post_vec_ready", vec_req_ready, 1);
        check_eq("t5_post_ext_stb", ext_stb, 0);
        check_eq("t5_post_vec_stb", vec_stb, 0);
        step();
        send(1'b0, 3'd5, 32'h55, 1'b1);
        send(1'b1, 3'd0, 32'hAA, 1'b1);
        drain();

        // Saturation under a long conflict burst
        sb_en = 1'b0;
        ext_req_valid = 1'b1; ext_req_sel = 3'd3; ext_req_data = 32'h5A;
        vec_req_valid = 1'b1; vec_req_sel = 3'd3; vec_req_data = 32'hA5;
        repeat (65545) step();
        @(negedge clk);
        check_eq("t6_cnt_sat", conflict_cnt, 32'hFFFF);
        step();
        @(negedge clk);
        check_eq("t6_cnt_hold", conflict_cnt, 32'hFFFF);
        step();
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("t6_rst_comb");
        step();
        @(negedge clk);
        check_idle_outputs("t6_rst_reg");
        check_eq("t6_rst_cnt", conflict_cnt, 0);
        check_eq("t6_rst_err", err_invalid_sel, 0);
        check_eq("t6_rst_ext_data", ext_data_out_exe, 0);
        check_eq("t6_rst_vec_data", vec_data_out_exe, 0);
        step();
        ext_req_valid = 1'b0; vec_req_valid = 1'b0;
        step();
        rst = 1'b1;
        sb_en = 1'b1;

        // rr_ptr back at ext after reset
        glog.delete();
        log_en = 1'b1;
        fork
            send(1'b0, 3'd3, 32'h91, 1'b1);
            send(1'b1, 3'd3, 32'h92, 1'b1);
        join
        drain();
        log_en = 1'b0;
        check_eq("t7_grants", glog.size(), 2);
        if (glog.size() > 0) check_eq("t7_ext_first", glog[0], 0);
        check_eq("t7_cnt", conflict_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
